// File: rtl/vga_box_pkg.sv
// Shared types, screen limits, palette and saturating axis arithmetic for the box engine.
package vga_box_pkg;

  localparam int unsigned H_ACTIVE_PIXEL_COUNT = 640;
  localparam int unsigned V_ACTIVE_LINE_COUNT  = 480;
  localparam int unsigned CNT_W                = 12;
  localparam int unsigned POS_W                = 11;
  localparam int unsigned ARITH_W              = 13;
  localparam int unsigned MAX_BOXES            = 8;

  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
  } box_pos_t;

  // 1 = moving towards smaller coordinates on that axis
  typedef struct packed {
    logic neg_x;
    logic neg_y;
  } dir_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Per-box {normal, alternate} colour
  localparam rgb_t PALETTE [MAX_BOXES][2] = '{
    '{24'hFF0000, 24'h800000},
    '{24'h00FF00, 24'h008000},
    '{24'h0000FF, 24'h000080},
    '{24'hFFFF00, 24'h808000},
    '{24'hFF00FF, 24'h800080},
    '{24'h00FFFF, 24'h008080},
    '{24'hFF8000, 24'h804000},
    '{24'h8080FF, 24'h404080}
  };

  // Saturate a signed intermediate to [0, lim]
  function automatic logic [POS_W-1:0] clamp(input logic signed [ARITH_W-1:0] val,
                                             input logic [POS_W-1:0] lim);
    logic signed [ARITH_W-1:0] lim_s;
    lim_s = $signed(ARITH_W'(lim));
    if (val < $signed(ARITH_W'(0))) return '0;
    else if (val > lim_s) return lim;
    return val[POS_W-1:0];
  endfunction

  // Key-driven axis step; opposing keys cancel
  function automatic logic [POS_W-1:0] manual_axis(input logic [POS_W-1:0] pos,
                                                   input logic inc, input logic dec,
                                                   input logic [ARITH_W-1:0] step,
                                                   input logic [POS_W-1:0] lim);
    logic [ARITH_W-1:0] nxt;
    nxt = ARITH_W'(pos);
    if (inc && !dec) nxt = nxt + step;
    else if (dec && !inc) nxt = nxt - step;
    return clamp($signed(nxt), lim);
  endfunction

  // Wall-bounce axis step; returns {direction, position}, direction flips on reaching a wall
  function automatic logic [POS_W:0] bounce_axis(input logic [POS_W-1:0] pos, input logic neg,
                                                 input logic [ARITH_W-1:0] step,
                                                 input logic [POS_W-1:0] lim);
    logic signed [ARITH_W-1:0] nxt;
    nxt = neg ? $signed(ARITH_W'(pos) - step) : $signed(ARITH_W'(pos) + step);
    if (nxt <= $signed(ARITH_W'(0))) return {~neg, POS_W'(0)};
    else if (nxt >= $signed(ARITH_W'(lim))) return {~neg, lim};
    return {neg, nxt[POS_W-1:0]};
  endfunction

endpackage

// File: rtl/vga_box_if.sv
// Timing-generator / control inputs and pixel outputs of the box engine.
interface vga_box_if
  import vga_box_pkg::*;
#(
  parameter int unsigned N_BOXES = 4
);
  logic [CNT_W-1:0]   h_counter;
  logic [CNT_W-1:0]   v_counter;
  logic               v_sync;
  logic [N_BOXES-1:0] move_en;
  logic               auto_mode;
  logic               fast;
  logic [3:0]         key_n;
  logic [N_BOXES-1:0] alt_colour;
  logic [7:0]         red;
  logic [7:0]         green;
  logic [7:0]         blue;
  logic               collide;

  modport master (
    output h_counter, v_counter, v_sync, move_en, auto_mode, fast, key_n, alt_colour,
    input  red, green, blue, collide
  );

  modport slave (
    input  h_counter, v_counter, v_sync, move_en, auto_mode, fast, key_n, alt_colour,
    output red, green, blue, collide
  );
endinterface

// File: rtl/vga_box_mover.sv
// Position/direction state of one box, updated once per frame tick.
module vga_box_mover
  import vga_box_pkg::*;
#(
  parameter int unsigned IDX         = 0,
  parameter int unsigned BOX_W       = 64,
  parameter int unsigned BOX_H       = 48,
  parameter int unsigned STEP_SLOW   = 2,
  parameter int unsigned STEP_FAST   = 6,
  parameter int unsigned INIT_STRIDE = 96
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       move_en,
  input  logic       auto_mode,
  input  logic       fast,
  input  logic [3:0] key_n,
  output box_pos_t   pos
);

  localparam logic [POS_W-1:0] XMAX   = POS_W'(H_ACTIVE_PIXEL_COUNT - BOX_W);
  localparam logic [POS_W-1:0] YMAX   = POS_W'(V_ACTIVE_LINE_COUNT - BOX_H);
  localparam logic [POS_W-1:0] INIT_X = clamp(ARITH_W'(IDX * INIT_STRIDE), XMAX);
  localparam logic [POS_W-1:0] INIT_Y = clamp(ARITH_W'(IDX * INIT_STRIDE), YMAX);

  dir_t               dir;
  dir_t               dir_nxt_c;
  box_pos_t           pos_nxt_c;
  logic [ARITH_W-1:0] step_c;
  logic [POS_W:0]     bx_c;
  logic [POS_W:0]     by_c;

  // Candidate next position for the current mode; key_n is {left,down,up,right}
  always_comb begin
    step_c    = fast ? ARITH_W'(STEP_FAST) : ARITH_W'(STEP_SLOW);
    bx_c      = bounce_axis(pos.x, dir.neg_x, step_c, XMAX);
    by_c      = bounce_axis(pos.y, dir.neg_y, step_c, YMAX);
    pos_nxt_c = pos;
    dir_nxt_c = dir;
    if (auto_mode) begin
      pos_nxt_c.x     = bx_c[POS_W-1:0];
      pos_nxt_c.y     = by_c[POS_W-1:0];
      dir_nxt_c.neg_x = bx_c[POS_W];
      dir_nxt_c.neg_y = by_c[POS_W];
    end else begin
      pos_nxt_c.x = manual_axis(pos.x, ~key_n[0], ~key_n[3], step_c, XMAX);
      pos_nxt_c.y = manual_axis(pos.y, ~key_n[2], ~key_n[1], step_c, YMAX);
    end
  end

  // Commit on the frame tick only; a disabled box keeps position and direction
  always_ff @(posedge clk) begin
    if (!rst) begin
      pos <= '{x: INIT_X, y: INIT_Y};
      dir <= '0;
    end else if (tick && move_en) begin
      pos <= pos_nxt_c;
      dir <= dir_nxt_c;
    end
  end

endmodule

// File: rtl/vga_box_engine.sv
// N-box sprite engine: per-frame movement, fixed-priority compositing, collision flag.
// Optional build macro VGA_BOX_OUTLINE_EN draws a 2-pixel white ring around each box.
module vga_box_engine
  import vga_box_pkg::*;
#(
  parameter int unsigned N_BOXES     = 4,
  parameter int unsigned BOX_W       = 64,
  parameter int unsigned BOX_H       = 48,
  parameter int unsigned STEP_SLOW   = 2,
  parameter int unsigned STEP_FAST   = 6,
  parameter int unsigned INIT_STRIDE = 96
) (
  input  logic     clk,
  input  logic     rst,
  vga_box_if.slave bus
);

  logic     v_sync_q;
  logic     tick_c;
  logic     coll_acc;
  logic     multi_c;
  rgb_t     pix_c;
  box_pos_t pos [N_BOXES];

  // Frame tick: first cycle v_sync is seen high
  always_comb begin
    tick_c = bus.v_sync & ~v_sync_q;
  end

  for (genvar i = 0; i < int'(N_BOXES); i++) begin : g_box
    vga_box_mover #(
      .IDX         (i),
      .BOX_W       (BOX_W),
      .BOX_H       (BOX_H),
      .STEP_SLOW   (STEP_SLOW),
      .STEP_FAST   (STEP_FAST),
      .INIT_STRIDE (INIT_STRIDE)
    ) u_mover (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick_c),
      .move_en   (bus.move_en[i]),
      .auto_mode (bus.auto_mode),
      .fast      (bus.fast),
      .key_n     (bus.key_n),
      .pos       (pos[i])
    );
  end

  // Hit test, lowest-index priority and >=2-hit detection for the current pixel
  always_comb begin : pix_mux
    logic               active;
    logic               seen;
    logic               hit;
    logic [ARITH_W-1:0] h_e;
    logic [ARITH_W-1:0] v_e;
    logic [ARITH_W-1:0] x_e;
    logic [ARITH_W-1:0] y_e;
    pix_c   = '0;
    multi_c = 1'b0;
    seen    = 1'b0;
    h_e     = ARITH_W'(bus.h_counter);
    v_e     = ARITH_W'(bus.v_counter);
    active  = (h_e < ARITH_W'(H_ACTIVE_PIXEL_COUNT)) && (v_e < ARITH_W'(V_ACTIVE_LINE_COUNT));
    for (int i = int'(N_BOXES) - 1; i >= 0; i--) begin
      x_e = ARITH_W'(pos[i].x);
      y_e = ARITH_W'(pos[i].y);
      hit = active && (h_e >= x_e) && (h_e < x_e + ARITH_W'(BOX_W)) &&
            (v_e >= y_e) && (v_e < y_e + ARITH_W'(BOX_H));
      multi_c = multi_c | (seen & hit);
      seen    = seen | hit;
      if (hit) begin
        pix_c = PALETTE[i][bus.alt_colour[i]];
`ifdef VGA_BOX_OUTLINE_EN
        if ((h_e < x_e + ARITH_W'(2)) || (h_e >= x_e + ARITH_W'(BOX_W - 2)) ||
            (v_e < y_e + ARITH_W'(2)) || (v_e >= y_e + ARITH_W'(BOX_H - 2))) begin
          pix_c = 24'hFFFFFF;
        end
`endif
      end
    end
  end

  // Registered RGB, tick history and per-frame collision accumulator
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.red     <= '0;
      bus.green   <= '0;
      bus.blue    <= '0;
      bus.collide <= 1'b0;
      coll_acc    <= 1'b0;
      v_sync_q    <= 1'b0;
    end else begin
      bus.red   <= pix_c.r;
      bus.green <= pix_c.g;
      bus.blue  <= pix_c.b;
      v_sync_q  <= bus.v_sync;
      if (tick_c) begin
        bus.collide <= coll_acc;
        coll_acc    <= multi_c;
      end else begin
        coll_acc <= coll_acc | multi_c;
      end
    end
  end

endmodule

// File: tb/tb_vga_box_engine.sv
// Randomised bench for vga_box_engine with an integer-arithmetic reference model.
module tb_vga_box_engine;

  localparam int NB   = 4;
  localparam int BW   = 64;
  localparam int BH   = 48;
  localparam int HA   = 640;
  localparam int VA   = 480;
  localparam int XMAX = HA - BW;
  localparam int YMAX = VA - BH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_box_if #(.N_BOXES(NB)) bus ();

  vga_box_engine #(
    .N_BOXES(NB), .BOX_W(BW), .BOX_H(BH), .STEP_SLOW(2), .STEP_FAST(6), .INIT_STRIDE(96)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  int          mx [NB];
  int          my [NB];
  int          mdx [NB];
  int          mdy [NB];
  bit          acc_m    = 1'b0;
  bit          vs_prev  = 1'b0;
  bit          chk_en   = 1'b0;
  logic [23:0] exp_rgb  = '0;
  logic        exp_col  = 1'b0;

  function automatic logic [23:0] pal(int i, bit alt);
    case (i)
      0: return alt ? 24'h800000 : 24'hFF0000;
      1: return alt ? 24'h008000 : 24'h00FF00;
      2: return alt ? 24'h000080 : 24'h0000FF;
      3: return alt ? 24'h808000 : 24'hFFFF00;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic int sat(int v, int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic bit covers(int i, int h, int v);
    return h < HA && v < VA && h >= mx[i] && h < mx[i] + BW && v >= my[i] && v < my[i] + BH;
  endfunction

  function automatic void reset_model();
    for (int i = 0; i < NB; i++) begin
      mx[i] = sat(i * 96, XMAX);
      my[i] = sat(i * 96, YMAX);
      mdx[i] = 1;
      mdy[i] = 1;
    end
  endfunction

  function automatic void move_box(int i);
    int st, nx, ny, dx, dy;
    st = bus.fast ? 6 : 2;
    if (bus.auto_mode) begin
      nx = mx[i] + mdx[i] * st;
      ny = my[i] + mdy[i] * st;
      if (nx <= 0) begin mx[i] = 0; mdx[i] = -mdx[i]; end
      else if (nx >= XMAX) begin mx[i] = XMAX; mdx[i] = -mdx[i]; end
      else mx[i] = nx;
      if (ny <= 0) begin my[i] = 0; mdy[i] = -mdy[i]; end
      else if (ny >= YMAX) begin my[i] = YMAX; mdy[i] = -mdy[i]; end
      else my[i] = ny;
    end else begin
      dx = int'(!bus.key_n[0]) - int'(!bus.key_n[3]);
      dy = int'(!bus.key_n[2]) - int'(!bus.key_n[1]);
      mx[i] = sat(mx[i] + dx * st, XMAX);
      my[i] = sat(my[i] + dy * st, YMAX);
    end
  endfunction

  // Reference model: expected next-cycle outputs from inputs seen at this edge
  always @(posedge clk) begin
    int h, v, nh, first;
    bit tk;
    if (!rst) begin
      reset_model();
      exp_rgb = '0;
      exp_col = 1'b0;
      acc_m   = 1'b0;
      vs_prev = 1'b0;
      chk_en  = 1'b1;
    end else begin
      h = int'(bus.h_counter);
      v = int'(bus.v_counter);
      nh = 0;
      first = -1;
      for (int i = 0; i < NB; i++) begin
        if (covers(i, h, v)) begin
          nh++;
          if (first < 0) first = i;
        end
      end
      exp_rgb = (first < 0) ? 24'h0 : pal(first, bus.alt_colour[first]);
`ifdef VGA_BOX_OUTLINE_EN
      if (first >= 0 && (h < mx[first] + 2 || h >= mx[first] + BW - 2 ||
                         v < my[first] + 2 || v >= my[first] + BH - 2)) exp_rgb = 24'hFFFFFF;
`endif
      tk = bus.v_sync && !vs_prev;
      vs_prev = bus.v_sync;
      if (tk) begin
        exp_col = acc_m;
        acc_m = (nh >= 2);
        for (int i = 0; i < NB; i++) if (bus.move_en[i]) move_box(i);
      end else if (nh >= 2) begin
        acc_m = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      checks += 2;
      if ({bus.red, bus.green, bus.blue} !== exp_rgb) begin
        failures++;
        $display("FAIL rgb t=%0t got=%h want=%h", $time, {bus.red, bus.green, bus.blue}, exp_rgb);
      end
      if (bus.collide !== exp_col) begin
        failures++;
        $display("FAIL collide t=%0t got=%b want=%b", $time, bus.collide, exp_col);
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic set_pix(int h, int v);
    @(posedge clk); #2;
    bus.h_counter = 12'(h);
    bus.v_counter = 12'(v);
  endtask

  task automatic probe(string name, int h, int v, logic [23:0] want);
    set_pix(h, v);
    @(posedge clk);
    @(negedge clk);
    chk(name, 32'({bus.red, bus.green, bus.blue}), 32'(want));
  endtask

  task automatic frame_tick(int hold = 1);
    @(posedge clk); #2 bus.v_sync = 1'b1;
    repeat (hold) @(posedge clk);
    #2 bus.v_sync = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
  endtask

  initial begin
    int h, v, b;
    bus.h_counter = 12'd700; bus.v_counter = 12'd700; bus.v_sync = 1'b0;
    bus.move_en = '0; bus.auto_mode = 1'b0; bus.fast = 1'b0;
    bus.key_n = 4'hF; bus.alt_colour = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h0);
    chk("reset_collide", 32'(bus.collide), 32'h0);
    @(posedge clk); #2 rst = 1'b1;

    // Manual slow right: three ticks move box0 from 0 to 6
    bus.move_en = 4'hF; bus.key_n = 4'b1110;
    repeat (3) frame_tick();
    chk("man_x", 32'(mx[0]), 32'd6);
    chk("man_y", 32'(my[0]), 32'd0);
    probe("man_left_edge", 6, 0, 24'hFF0000);
    probe("man_outside", 5, 0, 24'h0);

    // Saturation at XMAX and cancelling keys
    bus.fast = 1'b1;
    repeat (94) frame_tick();
    bus.fast = 1'b0; frame_tick();
    chk("sat_pre", 32'(mx[0]), 32'd572);
    bus.fast = 1'b1; frame_tick();
    chk("sat_xmax", 32'(mx[0]), 32'(XMAX));
    frame_tick();
    chk("sat_hold", 32'(mx[0]), 32'(XMAX));
    bus.key_n = 4'b0110; frame_tick();
    chk("lr_cancel", 32'(mx[0]), 32'(XMAX));
    probe("edge_br_in", 639, 47, 24'hFF0000);
    probe("edge_bottom", 639, 48, 24'h0);
    probe("edge_left_out", 575, 10, 24'h0);
    probe("h_active", 640, 10, 24'h0);

    // Overlap of boxes 0 and 1, priority, edges and collision flag
    do_reset();
    bus.move_en = 4'b0001; bus.key_n = 4'b1010; bus.fast = 1'b1;
    repeat (17) frame_tick();
    chk("ovl_x", 32'(mx[0]), 32'd102);
    bus.move_en = '0; bus.key_n = 4'hF;
    probe("ovl_prio", 120, 120, 24'hFF0000);
    set_pix(700, 700);
    frame_tick();
    @(negedge clk);
    chk("collide_set", 32'(bus.collide), 32'h1);
    frame_tick();
    @(negedge clk);
    chk("collide_clr", 32'(bus.collide), 32'h0);
    probe("right_in", 165, 110, 24'hFF0000);
    probe("right_excl", 166, 110, 24'h0);
    probe("box1_only", 101, 101, 24'h00FF00);
    probe("bottom_in", 110, 149, 24'hFF0000);
    probe("bottom_excl", 110, 150, 24'h0);
    bus.alt_colour = 4'b0001;
    probe("alt_colour", 120, 120, 24'h800000);
    bus.alt_colour = '0;
    set_pix(700, 700);

    // Autonomous bounce off the right and bottom walls
    do_reset();
    bus.auto_mode = 1'b1; bus.fast = 1'b1; bus.move_en = 4'b0001;
    repeat (96) frame_tick();
    chk("auto_xmax", 32'(mx[0]), 32'(XMAX));
    chk("auto_y", 32'(my[0]), 32'd288);
    frame_tick();
    chk("auto_back", 32'(mx[0]), 32'd570);
    probe("auto_pix", 570, 282, 24'hFF0000);
    probe("auto_pix_out", 569, 282, 24'h0);

    // One-cycle reset mid-frame
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    chk("midrst_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h0);
    chk("midrst_collide", 32'(bus.collide), 32'h0);
    probe("midrst_pos", 0, 0, 24'hFF0000);

    // Random frames
    for (int f = 0; f < 250; f++) begin
      bus.auto_mode  = 1'($urandom_range(1, 0));
      bus.fast       = 1'($urandom_range(1, 0));
      bus.key_n      = 4'($urandom);
      bus.move_en    = 4'($urandom);
      bus.alt_colour = 4'($urandom);
      for (int p = 0; p < 8; p++) begin
        if ($urandom_range(4, 0) == 0) begin
          h = int'($urandom_range(700, 0));
          v = int'($urandom_range(520, 0));
        end else begin
          b = int'($urandom_range(NB - 1, 0));
          h = sat(mx[b] + int'($urandom_range(70, 0)) - 3, 4095);
          v = sat(my[b] + int'($urandom_range(54, 0)) - 3, 4095);
        end
        set_pix(h, v);
      end
      frame_tick(int'($urandom_range(3, 1)));
      if ($urandom_range(39, 0) == 0) do_reset();
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
